seq_detect_scheduler: RTL and testbench

Time-multiplexed controller that shares one serial pattern-detection engine among NCH independent bit streams. A round-robin arbiter accepts at most one bit per cycle from the requesting channels. Per-channel detector context (bit history and fill count) is saved and restored around each accepted bit. The detection pattern and overlap mode are programmed through a config handshake; detections are reported as a registered pulse tagged with the channel number.

---
 rtl/seq_detect_scheduler_pkg.sv | 36 +++
 rtl/seq_detect_scheduler_if.sv | 34 +++
 rtl/seq_detect_scheduler_rr_arbiter.sv | 48 ++++
 rtl/seq_detect_scheduler.sv | 125 ++++++++++++
 tb/tb_seq_detect_scheduler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed sequence detector.
//   state_t        : controller states (UNCFG, FLUSH, RUN)
//   MATCH_CNT_W    : width of the saturating match counter
//   MATCH_CNT_MAX  : saturation value of the match counter
//   next_rr_grant  : one-hot round-robin grant, first requester at/after ptr
package seq_detect_pkg;

   typedef enum logic [1:0] {
      ST_UNCFG,
      ST_FLUSH,
      ST_RUN
   } state_t;

   localparam int unsigned MATCH_CNT_W = 16;
   localparam logic [MATCH_CNT_W-1:0] MATCH_CNT_MAX = '1;
   localparam int unsigned MAX_NCH = 16;

   // Vectors are sized for the largest supported channel count; only the
   // low nch bits are meaningful. The search wraps at nch, not at MAX_NCH.
   function automatic logic [MAX_NCH-1:0] next_rr_grant(
      input logic [MAX_NCH-1:0] valid,
      input logic [3:0]         ptr,
      input int unsigned        nch
   );
      logic [MAX_NCH-1:0] g;
      logic [3:0]         idx;
      g = '0;
      for (int unsigned i = 0; i < MAX_NCH; i++) begin
         idx = 4'((32'(ptr) + i) % nch);
         if (i < nch && g == '0 && valid[idx])
            g[idx] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Config / channel / match signal bundle for seq_detect_scheduler.
//   master : drives cfg_valid/pattern/overlap, ch_valid, ch_bit
//   slave  : drives cfg_ready, ch_ready, match_valid/ch/count, busy
interface seq_detect_scheduler_if
   import seq_detect_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned PLEN = 4
);
   localparam int unsigned CW = $clog2(NCH);

   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [PLEN-1:0]        cfg_pattern;
   logic                   cfg_overlap;
   logic [NCH-1:0]         ch_valid;
   logic [NCH-1:0]         ch_bit;
   logic [NCH-1:0]         ch_ready;
   logic                   match_valid;
   logic [CW-1:0]          match_ch;
   logic [MATCH_CNT_W-1:0] match_count;
   logic                   busy;

   modport master (
      output cfg_valid, cfg_pattern, cfg_overlap, ch_valid, ch_bit,
      input  cfg_ready, ch_ready, match_valid, match_ch, match_count, busy
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_overlap, ch_valid, ch_bit,
      output cfg_ready, ch_ready, match_valid, match_ch, match_count, busy
   );

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// Round-robin arbiter with internal pointer.
//   clk, reset : clock, synchronous active-high reset
//   i_req      : per-channel request
//   i_enable   : grants are forced to zero when low
//   o_grant    : one-hot combinational grant, subset of i_req
module rr_arbiter
   import seq_detect_pkg::*;
#(
   parameter int unsigned NCH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] i_req,
   input  logic           i_enable,
   output logic [NCH-1:0] o_grant
);
   localparam int unsigned CW = $clog2(NCH);

   logic [CW-1:0]      r_ptr;
   logic [MAX_NCH-1:0] w_req_ext;
   logic [MAX_NCH-1:0] w_grant_ext;
   logic [CW-1:0]      w_gidx;
   logic               w_unused_grant;

   always_comb begin
      w_req_ext          = '0;
      w_req_ext[NCH-1:0] = i_req;
   end

   assign w_grant_ext    = next_rr_grant(w_req_ext, 4'(r_ptr), NCH);
   assign o_grant        = i_enable ? w_grant_ext[NCH-1:0] : '0;
   // Bits above NCH are always zero from the helper.
   assign w_unused_grant = ^w_grant_ext;

   always_comb begin
      w_gidx = '0;
      for (int unsigned i = 0; i < NCH; i++)
         if (o_grant[i]) w_gidx = CW'(i);
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (|o_grant)
         r_ptr <= (w_gidx == CW'(NCH-1)) ? '0 : w_gidx + CW'(1);
   end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Shares one serial pattern detector among NCH bit streams. A round-robin
// arbiter accepts at most one bit per cycle; per-channel history and fill
// count are kept in context arrays and updated on the granted channel.
//   clk, reset : clock, synchronous active-high reset
//   bus.cfg_*  : pattern/overlap programming handshake
//   bus.ch_*   : per-channel valid/bit in, one-hot ready out
//   bus.match_*: registered detection pulse, channel tag, saturating count
//   bus.busy   : high in RUN
module seq_detect_scheduler
   import seq_detect_pkg::*;
#(
   parameter int unsigned NCH  = 4,
   parameter int unsigned PLEN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   seq_detect_scheduler_if.slave bus
);
   localparam int unsigned CW = $clog2(NCH);
   localparam int unsigned FW = $clog2(PLEN);

   state_t                 r_state;
   logic [PLEN-1:0]        r_pattern;
   logic                   r_overlap;
   logic [PLEN-2:0]        r_hist [NCH];
   logic [FW-1:0]          r_fill [NCH];
   logic                   r_match_valid;
   logic [CW-1:0]          r_match_ch;
   logic [MATCH_CNT_W-1:0] r_match_count;

   logic                   w_cfg_ready;
   logic                   w_cfg_accept;
   logic                   w_arb_en;
   logic [NCH-1:0]         w_grant;
   logic                   w_xfer;
   logic [CW-1:0]          w_gidx;
   logic [PLEN-1:0]        w_word;
   logic                   w_full;
   logic                   w_hit;

   assign w_cfg_ready  = (r_state != ST_FLUSH);
   assign w_cfg_accept = bus.cfg_valid & w_cfg_ready;
   // A config accept in RUN wins over channel traffic for that cycle.
   assign w_arb_en     = (r_state == ST_RUN) & ~bus.cfg_valid;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req    (bus.ch_valid),
      .i_enable (w_arb_en),
      .o_grant  (w_grant)
   );

   assign w_xfer = |w_grant;

   always_comb begin
      w_gidx = '0;
      for (int unsigned i = 0; i < NCH; i++)
         if (w_grant[i]) w_gidx = CW'(i);
   end

   assign w_word = {r_hist[w_gidx], bus.ch_bit[w_gidx]};
   assign w_full = (r_fill[w_gidx] == FW'(PLEN-1));
   assign w_hit  = w_xfer && (w_word == r_pattern) && w_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_UNCFG;
         r_pattern     <= '0;
         r_overlap     <= 1'b0;
         r_match_valid <= 1'b0;
         r_match_ch    <= '0;
         r_match_count <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            r_hist[i] <= '0;
            r_fill[i] <= '0;
         end
      end else begin
         r_match_valid <= w_hit;
         if (w_hit) begin
            r_match_ch <= w_gidx;
            if (r_match_count != MATCH_CNT_MAX)
               r_match_count <= r_match_count + 1'b1;
         end

         if (w_xfer) begin
            if (w_hit && !r_overlap) begin
               r_hist[w_gidx] <= '0;
               r_fill[w_gidx] <= '0;
            end else begin
               r_hist[w_gidx] <= w_word[PLEN-2:0];
               if (!w_full)
                  r_fill[w_gidx] <= r_fill[w_gidx] + FW'(1);
            end
         end

         case (r_state)
            ST_UNCFG, ST_RUN: begin
               if (w_cfg_accept) begin
                  r_pattern <= bus.cfg_pattern;
                  r_overlap <= bus.cfg_overlap;
                  r_state   <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               r_match_count <= '0;
               for (int unsigned i = 0; i < NCH; i++) begin
                  r_hist[i] <= '0;
                  r_fill[i] <= '0;
               end
               r_state <= ST_RUN;
            end
            default: r_state <= ST_UNCFG;
         endcase
      end
   end

   assign bus.cfg_ready   = w_cfg_ready;
   assign bus.ch_ready    = w_grant;
   assign bus.match_valid = r_match_valid;
   assign bus.match_ch    = r_match_ch;
   assign bus.match_count = r_match_count;
   assign bus.busy        = (r_state == ST_RUN);

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed scenarios plus randomized traffic against a behavioural model
// of seq_detect_scheduler.
module tb_seq_detect_scheduler;
   localparam int unsigned NCH  = 4;
   localparam int unsigned PLEN = 4;
   localparam int MASK = (1 << PLEN) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_detect_scheduler_if #(.NCH(NCH), .PLEN(PLEN)) bus ();

   seq_detect_scheduler #(.NCH(NCH), .PLEN(PLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: 0 = unconfigured, 1 = flush, 2 = run.
   int m_state;
   int m_ptr;
   int m_pat;
   int m_ovl;
   int m_cnt;
   int m_last_ch;
   int m_hv [NCH];   // last bits received, newest in bit 0
   int m_n  [NCH];   // bits received since last restart

   int s1101 [4] = '{1, 1, 0, 1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_pat = 0; m_ovl = 0; m_cnt = 0; m_last_ch = 0;
      for (int i = 0; i < NCH; i++) begin m_hv[i] = 0; m_n[i] = 0; end
   endtask

   // One clock cycle; called at posedge+1.
   task automatic step(input bit cv, input int pat, input bit ovl,
                       input logic [NCH-1:0] v, input logic [NCH-1:0] b);
      int gi;
      bit hit;
      bus.cfg_valid   = cv;
      bus.cfg_pattern = PLEN'(pat);
      bus.cfg_overlap = ovl;
      bus.ch_valid    = v;
      bus.ch_bit      = b;
      #1;
      gi = -1;
      if (m_state == 2 && !cv)
         for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_ptr + i) % NCH;
            if (gi < 0 && v[c]) gi = c;
         end
      chk("ch_ready", 32'(bus.ch_ready), (gi < 0) ? 32'd0 : (32'd1 << gi));
      chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_state != 1));
      chk("busy", 32'(bus.busy), 32'(m_state == 2));
      hit = 1'b0;
      if (gi >= 0) begin
         m_ptr = (gi + 1) % NCH;
         m_hv[gi] = ((m_hv[gi] << 1) | int'(b[gi])) & MASK;
         m_n[gi]++;
         if (m_n[gi] >= PLEN && m_hv[gi] == m_pat) begin
            hit = 1'b1;
            m_last_ch = gi;
            if (m_cnt < 65535) m_cnt++;
            if (m_ovl == 0) begin m_hv[gi] = 0; m_n[gi] = 0; end
         end
      end
      case (m_state)
         0, 2: if (cv) begin m_pat = pat & MASK; m_ovl = int'(ovl); m_state = 1; end
         default: begin
            m_state = 2; m_cnt = 0;
            for (int i = 0; i < NCH; i++) begin m_hv[i] = 0; m_n[i] = 0; end
         end
      endcase
      @(posedge clk); #1;
      chk("match_valid", 32'(bus.match_valid), 32'(hit));
      chk("match_ch", 32'(bus.match_ch), 32'(m_last_ch));
      chk("match_count", 32'(bus.match_count), 32'(m_cnt));
   endtask

   task automatic send(input int ch, input int bv);
      step(1'b0, 0, 1'b0, NCH'(1) << ch, NCH'(bv) << ch);
   endtask

   task automatic configure(input int pat, input bit ovl);
      step(1'b1, pat, ovl, '0, '0);
      step(1'b0, 0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_overlap = 1'b0;
      bus.ch_valid = '0; bus.ch_bit = '0;
      @(posedge clk); #1;
      chk("rst_match_valid", 32'(bus.match_valid), 32'd0);
      chk("rst_match_ch", 32'(bus.match_ch), 32'd0);
      chk("rst_match_count", 32'(bus.match_count), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ch_ready", 32'(bus.ch_ready), 32'd0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      do_reset();
      // Traffic before configuration must not be granted.
      step(1'b0, 0, 1'b0, '1, '1);
      step(1'b0, 0, 1'b0, '1, '0);

      // Overlapping detection of 1101 on ch0.
      configure(4'b1101, 1'b1);
      foreach (s1101[i]) send(0, s1101[i]);
      for (int i = 1; i < 4; i++) send(0, s1101[i]);
      chk("s1_count", 32'(bus.match_count), 32'd2);

      // Non-overlapping: second window restarts after the first match.
      configure(4'b1101, 1'b0);
      foreach (s1101[i]) send(0, s1101[i]);
      for (int i = 1; i < 4; i++) send(0, s1101[i]);
      chk("s2_count", 32'(bus.match_count), 32'd1);

      // Two channels alternate under round-robin.
      do_reset();
      configure(4'b1101, 1'b1);
      for (int k = 0; k < 8; k++)
         step(1'b0, 0, 1'b0, 4'b0101, (s1101[k/2] != 0) ? 4'b0101 : 4'b0000);
      chk("s3_count", 32'(bus.match_count), 32'd2);
      chk("s3_last_ch", 32'(bus.match_ch), 32'd2);

      // All-zero pattern: fill gating suppresses early matches.
      configure(4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) send(1, 0);
      chk("s4_count", 32'(bus.match_count), 32'd2);

      // Reconfig in RUN discards partial history.
      configure(4'b1101, 1'b1);
      send(0, 1); send(0, 1); send(0, 0);
      step(1'b1, 4'b1101, 1'b1, 4'b0001, 4'b0001);
      step(1'b0, 0, 1'b0, 4'b0001, 4'b0001);
      send(0, 1);
      chk("s5_no_match", 32'(bus.match_count), 32'd0);
      foreach (s1101[i]) send(0, s1101[i]);
      chk("s5_count", 32'(bus.match_count), 32'd1);

      // Reset mid-stream.
      send(2, 1); send(2, 1);
      do_reset();
      step(1'b0, 0, 1'b0, '1, '1);

      // Randomized traffic with occasional reconfiguration.
      configure(int'($urandom_range(0, MASK)), 1'($urandom));
      for (int k = 0; k < 600; k++) begin
         bit cv;
         cv = ($urandom_range(0, 59) == 0);
         step(cv, int'($urandom_range(0, MASK)), 1'($urandom),
              NCH'($urandom), NCH'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
